vga_ball_ctrl: RTL and testbench

//  Frame-rate motion controller for the bouncing ball. Collects edge-collision pulses from
//  vga_screenedge (pre-qualified with the ball pixel at top level) during the visible frame,

---
 rtl/vga_ball_ctrl.sv | 167 ++++++++++++++++
 tb/tb_vga_ball_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ball_ctrl.sv
// Per-frame motion controller for the bouncing ball: gathers edge hits while the frame is visible,
// then updates direction and position during vertical blanking. Optional macro: BOUNCE_COUNT_EN.
module vga_ball_ctrl #(
  parameter int BALL_SIZE = 8,
  parameter int STEP      = 2,
  parameter int X_INIT    = 316,
  parameter int Y_INIT    = 236,
  parameter int EDGE      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vidactive,
  input  logic [9:0]  xpos_vga,
  input  logic [9:0]  ypos_vga,
  input  logic        collision_top,
  input  logic        collision_right,
  input  logic        collision_bottom,
  input  logic        collision_left,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        ball_pixel,
  output logic        update_done,
`ifdef BOUNCE_COUNT_EN
  output logic [15:0] bounce_count,
`endif
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] APPLY   = 2'd1;
  localparam logic [1:0] MOVE    = 2'd2;

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] X_MIN  = 11'(EDGE);
  localparam logic [10:0] X_MAX  = 11'(640 - EDGE - BALL_SIZE);
  localparam logic [10:0] Y_MIN  = 11'(EDGE);
  localparam logic [10:0] Y_MAX  = 11'(480 - EDGE - BALL_SIZE);
  localparam logic [10:0] SIZE_W = 11'(BALL_SIZE);

  logic [1:0]  state;
  logic        frame_tick;
  logic        hit_t, hit_r, hit_b, hit_l;
  logic        dir_x_apply, dir_y_apply;
  logic [10:0] x_sum, y_sum;
  logic        x_low, x_high, y_low, y_high;
  logic [9:0]  x_next, y_next;
  logic        dir_x_move, dir_y_move;

  assign fsm_state = state;

  // Tick marks the first blanking line; registered so it lines up with the FSM edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= (xpos_vga == 10'd0) && (ypos_vga == 10'd480);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      case (state)
        COLLECT: if (frame_tick) state <= APPLY;
        APPLY:   state <= MOVE;
        MOVE:    state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

  // A pulse during APPLY/MOVE survives the clear so it counts for the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_t <= 1'b0;
      hit_r <= 1'b0;
      hit_b <= 1'b0;
      hit_l <= 1'b0;
    end else begin
      hit_t <= collision_top    | (hit_t & (state != APPLY));
      hit_r <= collision_right  | (hit_r & (state != APPLY));
      hit_b <= collision_bottom | (hit_b & (state != APPLY));
      hit_l <= collision_left   | (hit_l & (state != APPLY));
    end
  end

  always_comb begin
    dir_x_apply = dir_x;
    dir_y_apply = dir_y;
    if (hit_l && !hit_r)      dir_x_apply = 1'b0;
    else if (hit_r && !hit_l) dir_x_apply = 1'b1;
    if (hit_t && !hit_b)      dir_y_apply = 1'b0;
    else if (hit_b && !hit_t) dir_y_apply = 1'b1;
  end

  // Bit 10 of a leftward/upward sum only sets on wrap below zero.
  always_comb begin
    x_sum  = dir_x ? ({1'b0, ball_x} + STEP_W) : ({1'b0, ball_x} - STEP_W);
    y_sum  = dir_y ? ({1'b0, ball_y} + STEP_W) : ({1'b0, ball_y} - STEP_W);
    x_low  = (!dir_x && x_sum[10]) || (x_sum < X_MIN);
    x_high = !x_low && (x_sum > X_MAX);
    y_low  = (!dir_y && y_sum[10]) || (y_sum < Y_MIN);
    y_high = !y_low && (y_sum > Y_MAX);

    x_next     = x_sum[9:0];
    dir_x_move = dir_x;
    if (x_low) begin
      x_next     = X_MIN[9:0];
      dir_x_move = 1'b1;
    end else if (x_high) begin
      x_next     = X_MAX[9:0];
      dir_x_move = 1'b0;
    end

    y_next     = y_sum[9:0];
    dir_y_move = dir_y;
    if (y_low) begin
      y_next     = Y_MIN[9:0];
      dir_y_move = 1'b1;
    end else if (y_high) begin
      y_next     = Y_MAX[9:0];
      dir_y_move = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x      <= 10'(X_INIT);
      ball_y      <= 10'(Y_INIT);
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      update_done <= 1'b0;
    end else begin
      update_done <= (state == APPLY);
      if (state == APPLY) begin
        dir_x <= dir_x_apply;
        dir_y <= dir_y_apply;
      end else if (state == MOVE) begin
        ball_x <= x_next;
        ball_y <= y_next;
        dir_x  <= dir_x_move;
        dir_y  <= dir_y_move;
      end
    end
  end

`ifdef BOUNCE_COUNT_EN
  // Only collision-driven reversals count; clamp reversals in MOVE do not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bounce_count <= 16'd0;
    end else if ((state == APPLY) && ((dir_x_apply != dir_x) || (dir_y_apply != dir_y))
                 && (bounce_count != 16'hFFFF)) begin
      bounce_count <= bounce_count + 16'd1;
    end
  end
`endif

  always_comb begin
    ball_pixel = vidactive
              && ({1'b0, xpos_vga} >= {1'b0, ball_x})
              && ({1'b0, xpos_vga} <  ({1'b0, ball_x} + SIZE_W))
              && ({1'b0, ypos_vga} >= {1'b0, ball_y})
              && ({1'b0, ypos_vga} <  ({1'b0, ball_y} + SIZE_W));
  end

endmodule

// File: tb/tb_vga_ball_ctrl.sv
// Self-checking bench for vga_ball_ctrl: a per-frame reference model feeds an expected queue
// that is popped when update_done marks the end of each frame update.
module tb_vga_ball_ctrl;

  localparam logic [3:0] H_T = 4'b1000;
  localparam logic [3:0] H_R = 4'b0100;
  localparam logic [3:0] H_B = 4'b0010;
  localparam logic [3:0] H_L = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vidactive = 1'b0;
  logic [9:0]  xpos_vga = 10'd1;
  logic [9:0]  ypos_vga = 10'd0;
  logic        collision_top = 1'b0;
  logic        collision_right = 1'b0;
  logic        collision_bottom = 1'b0;
  logic        collision_left = 1'b0;
  logic [9:0]  ball_x, ball_y;
  logic        dir_x, dir_y, ball_pixel, update_done;
  logic [1:0]  fsm_state;
`ifdef BOUNCE_COUNT_EN
  logic [15:0] bounce_count;
`endif

  int errors = 0;
  int checks = 0;

  // Expected {dir_x, dir_y, ball_x, ball_y} after each frame update.
  logic [21:0] exp_q[$];
  int   m_x, m_y, m_bc;
  logic m_dx, m_dy;
  logic [3:0] m_late;

  vga_ball_ctrl dut (
    .clk(clk), .reset(reset), .vidactive(vidactive),
    .xpos_vga(xpos_vga), .ypos_vga(ypos_vga),
    .collision_top(collision_top), .collision_right(collision_right),
    .collision_bottom(collision_bottom), .collision_left(collision_left),
    .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
    .ball_pixel(ball_pixel), .update_done(update_done),
`ifdef BOUNCE_COUNT_EN
    .bounce_count(bounce_count),
`endif
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_x = 316; m_y = 236; m_dx = 1'b1; m_dy = 1'b1; m_bc = 0; m_late = 4'b0000;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] h);
    logic ndx, ndy;
    int nx, ny;
    ndx = m_dx; ndy = m_dy;
    if (h[0] && !h[2]) ndx = 1'b0; else if (h[2] && !h[0]) ndx = 1'b1;
    if (h[3] && !h[1]) ndy = 1'b0; else if (h[1] && !h[3]) ndy = 1'b1;
    if (((ndx != m_dx) || (ndy != m_dy)) && (m_bc != 65535)) m_bc++;
    nx = ndx ? m_x + 2 : m_x - 2;
    ny = ndy ? m_y + 2 : m_y - 2;
    if (nx < 5) begin nx = 5; ndx = 1'b1; end
    else if (nx > 627) begin nx = 627; ndx = 1'b0; end
    if (ny < 5) begin ny = 5; ndy = 1'b1; end
    else if (ny > 467) begin ny = 467; ndy = 1'b0; end
    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
  endtask

  task automatic set_coll(input logic [3:0] h);
    {collision_top, collision_right, collision_bottom, collision_left} = h;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    set_coll(4'b0000);
    vidactive = 1'b0; xpos_vga = 10'd1; ypos_vga = 10'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // hits: pulsed while the frame is visible; late: pulsed during the APPLY cycle.
  task automatic do_frame(input logic [3:0] hits, input logic [3:0] late);
    int lat;
    bit seen;
    logic [21:0] exp_v, got;
    model_step(hits | m_late);
    m_late = late;
    exp_q.push_back({m_dx, m_dy, 10'(m_x), 10'(m_y)});

    @(negedge clk);
    vidactive = 1'b1; xpos_vga = 10'd100; ypos_vga = 10'd100;
    set_coll(hits);
    @(negedge clk);
    set_coll(4'b0000);
    @(negedge clk);
    vidactive = 1'b0; xpos_vga = 10'd0; ypos_vga = 10'd480;
    lat = 0; seen = 0;
    while (lat < 8 && !seen) begin
      @(negedge clk);
      lat++;
      if (lat == 1) ypos_vga = 10'd481;
      if (lat == 2) set_coll(late); else set_coll(4'b0000);
      if (update_done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || lat != 3) begin
      errors++;
      $display("FAIL update_done_latency: got %0d edges (seen=%0d), need 3", lat, seen);
    end
    @(negedge clk);
    checks++;
    if (update_done !== 1'b0) begin
      errors++;
      $display("FAIL update_done_width: got %b, need 0", update_done);
    end
    exp_v = exp_q.pop_front();
    got = {dir_x, dir_y, ball_x, ball_y};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL frame_state: got dx=%b dy=%b x=%0d y=%0d, need dx=%b dy=%b x=%0d y=%0d",
               got[21], got[20], got[19:10], got[9:0],
               exp_v[21], exp_v[20], exp_v[19:10], exp_v[9:0]);
    end
`ifdef BOUNCE_COUNT_EN
    checks++;
    if (bounce_count !== 16'(m_bc)) begin
      errors++;
      $display("FAIL bounce_count: got %0d, need %0d", bounce_count, m_bc);
    end
`endif
    xpos_vga = 10'd1; ypos_vga = 10'd0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({dir_x, dir_y, ball_x, ball_y, update_done, fsm_state} !==
        {1'b1, 1'b1, 10'd316, 10'd236, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: got dx=%b dy=%b x=%0d y=%0d done=%b st=%0d, need 1 1 316 236 0 0",
               dir_x, dir_y, ball_x, ball_y, update_done, fsm_state);
    end
  endtask

  task automatic test_ball_pixel();
    logic [9:0] px[5];
    logic [9:0] py[5];
    logic       va[5];
    logic       ex[5];
    px = '{10'd316, 10'd323, 10'd324, 10'd320, 10'd318};
    py = '{10'd236, 10'd243, 10'd240, 10'd235, 10'd238};
    va = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0};
    ex = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vidactive = va[i]; xpos_vga = px[i]; ypos_vga = py[i];
      #1;
      checks++;
      if (ball_pixel !== ex[i]) begin
        errors++;
        $display("FAIL ball_pixel[%0d]: got %b at (%0d,%0d) va=%b, need %b",
                 i, ball_pixel, px[i], py[i], va[i], ex[i]);
      end
    end
    @(negedge clk);
    vidactive = 1'b0; xpos_vga = 10'd1; ypos_vga = 10'd0;
  endtask

  task automatic test_collisions();
    do_frame(4'b0000, 4'b0000);   // free move: 318,238
    do_frame(H_L, 4'b0000);       // reverse x
    do_frame(H_R, 4'b0000);       // back to right
    do_frame(H_L | H_R, 4'b0000); // both: x keeps going right
    do_frame(H_T | H_B, 4'b0000); // both: y unchanged
    do_frame(H_T, 4'b0000);       // up
    do_frame(H_B, 4'b0000);       // down
  endtask

  task automatic test_late_hit();
    do_frame(4'b0000, H_T);
    checks++;
    if (dir_y !== 1'b1) begin
      errors++;
      $display("FAIL late_hit_not_now: got dir_y=%b, need 1", dir_y);
    end
    do_frame(4'b0000, 4'b0000);
    checks++;
    if (dir_y !== 1'b0) begin
      errors++;
      $display("FAIL late_hit_next: got dir_y=%b, need 0", dir_y);
    end
  endtask

  task automatic test_clamp();
    apply_reset();
    for (int i = 0; i < 156; i++) do_frame(4'b0000, 4'b0000);
    checks++;
    if ({ball_x, dir_x, ball_y, dir_y} !== {10'd627, 1'b0, 10'd387, 1'b0}) begin
      errors++;
      $display("FAIL clamp_run: got x=%0d dx=%b y=%0d dy=%b, need 627 0 387 0",
               ball_x, dir_x, ball_y, dir_y);
    end
    do_frame(4'b0000, 4'b0000);
  endtask

  task automatic test_reset_during_move();
    int lat;
    apply_reset();
    do_frame(H_L, 4'b0000);
    @(negedge clk);
    xpos_vga = 10'd0; ypos_vga = 10'd480;
    lat = 0;
    while (lat < 3) begin
      @(negedge clk);
      lat++;
      ypos_vga = 10'd481;
    end
    checks++;
    if (update_done !== 1'b1 || fsm_state !== 2'd2) begin
      errors++;
      $display("FAIL move_reached: got done=%b st=%0d, need 1 2", update_done, fsm_state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({dir_x, dir_y, ball_x, ball_y, update_done, fsm_state} !==
        {1'b1, 1'b1, 10'd316, 10'd236, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_in_move: got dx=%b dy=%b x=%0d y=%0d done=%b st=%0d, need 1 1 316 236 0 0",
               dir_x, dir_y, ball_x, ball_y, update_done, fsm_state);
    end
`ifdef BOUNCE_COUNT_EN
    checks++;
    if (bounce_count !== 16'd0) begin
      errors++;
      $display("FAIL bounce_reset: got %0d, need 0", bounce_count);
    end
`endif
    @(negedge clk);
    xpos_vga = 10'd1; ypos_vga = 10'd0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_frame(4'b0000, 4'b0000);
    checks++;
    if ({ball_x, ball_y} !== {10'd318, 10'd238}) begin
      errors++;
      $display("FAIL after_reset_frame: got x=%0d y=%0d, need 318 238", ball_x, ball_y);
    end
  endtask

`ifdef BOUNCE_COUNT_EN
  task automatic test_bounce_count();
    apply_reset();
    do_frame(H_L, 4'b0000);
    do_frame(H_R, 4'b0000);
    do_frame(H_T, 4'b0000);
    checks++;
    if (bounce_count !== 16'd3) begin
      errors++;
      $display("FAIL bounce_three: got %0d, need 3", bounce_count);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_ball_pixel();
    test_collisions();
    test_late_hit();
    test_clamp();
    test_reset_during_move();
`ifdef BOUNCE_COUNT_EN
    test_bounce_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
